// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit for the execute stage.
// Multiply: radix-2 Booth over WIDTH cycles. Divide: restoring division on
// magnitudes over WIDTH cycles, then a one-cycle sign/exception fix-up.
// Handshake: a start is ctrl_MULT or ctrl_DIV high at a clock edge and is
// always accepted (an operation in flight is abandoned without a result).
// busy is high while an operation is in flight. data_resultRDY is a
// single-cycle pulse that qualifies data_result/data_exception, which stay
// held afterwards. The FSM state is held in state_q (type state_t).
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;       // original operand A
  logic [WIDTH-1:0] b_q, b_d;       // original operand B
  logic [WIDTH-1:0] hi_q, hi_d;     // Booth P_hi / division remainder R
  logic [WIDTH-1:0] lo_q, lo_d;     // Booth P_lo / division quotient Q
  logic             qm1_q, qm1_d;   // Booth q_-1
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;

  // Datapath temporaries
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] b_abs;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  // Next-state logic: start handling, Booth step, restoring-divide step, fix-up
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    qm1_d     = qm1_q;
    res_d     = res_q;
    exc_d     = exc_q;
    booth_sum = {hi_q[WIDTH-1], hi_q};
    b_abs     = b_q[WIDTH-1] ? -b_q : b_q;
    rem_shift = {hi_q, lo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_abs};

    if (ctrl_MULT || ctrl_DIV) begin
      // Any start restarts the unit; multiply wins when both are asserted
      cnt_d = '0;
      a_d   = data_operandA;
      b_d   = data_operandB;
      hi_d  = '0;
      qm1_d = 1'b0;
      exc_d = 1'b0;
      if (ctrl_MULT) begin
        state_d = MUL_RUN;
        lo_d    = data_operandB;
      end else begin
        state_d = DIV_RUN;
        lo_d    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      end
    end else begin
      case (state_q)
        MUL_RUN: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_d = DONE;
            res_d   = lo_q;
            exc_d   = (hi_q != {WIDTH{lo_q[WIDTH-1]}});
          end else begin
            // WIDTH+1 bit add/sub so that subtracting -2^(WIDTH-1) keeps its sign
            case ({lo_q[0], qm1_q})
              2'b01:   booth_sum = {hi_q[WIDTH-1], hi_q} + {a_q[WIDTH-1], a_q};
              2'b10:   booth_sum = {hi_q[WIDTH-1], hi_q} - {a_q[WIDTH-1], a_q};
              default: booth_sum = {hi_q[WIDTH-1], hi_q};
            endcase
            hi_d  = booth_sum[WIDTH:1];
            lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
            qm1_d = lo_q[0];
            cnt_d = cnt_q + CW'(1);
          end
        end
        DIV_RUN: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_d = DIV_FIX;
          end else begin
            if (rem_shift >= {1'b0, b_abs}) begin
              hi_d = rem_diff[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_d = rem_shift[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
          end
        end
        DIV_FIX: begin
          state_d = DONE;
          if (b_q == '0) begin
            res_d = '0;
            exc_d = 1'b1;
          end else if (a_q == MIN_NEG && b_q == ALL_ONES) begin
            res_d = MIN_NEG;
            exc_d = 1'b1;
          end else begin
            res_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) ? -lo_q : lo_q;
            exc_d = 1'b0;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    data_result    = res_q;
    data_exception = exc_q;
    data_resultRDY = (state_q == DONE);
    busy           = (state_q == MUL_RUN) || (state_q == DIV_RUN) || (state_q == DIV_FIX);
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter: latency, results, exceptions, restart and reset.
module tb_multdiv_iter;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  multdiv_iter #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Clock and reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a start pulse so that the following rising edge is edge 0
  task automatic start_op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Wait (bounded) for RDY after a start; cycle k is the cycle after edge k-1
  task automatic wait_and_check(input string tag, input int exp_cyc, input logic [31:0] exp_res,
                                input logic exp_exc);
    int rdy_cyc = 0;
    int busy_cnt = 0;
    int overlap = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (data_resultRDY) begin
        rdy_cyc = cyc;
        if (busy) overlap++;
        break;
      end
    end
    check({tag, "_rdy_cycle"}, rdy_cyc, exp_cyc);
    check({tag, "_busy_cycles"}, busy_cnt, exp_cyc - 1);
    check({tag, "_busy_rdy_overlap"}, overlap, 0);
    check({tag, "_result"}, data_result, exp_res);
    check({tag, "_exception"}, {31'b0, data_exception}, {31'b0, exp_exc});
    @(negedge clock);
    check({tag, "_rdy_one_cycle"}, {31'b0, data_resultRDY}, 32'd0);
    check({tag, "_result_held"}, data_result, exp_res);
  endtask

  initial begin
    int rdy_seen;
    int busy_seen;
    reset         = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'b0, data_exception}, 32'd0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;

    // Multiply
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    wait_and_check("mul_7x-6", 34, 32'hFFFF_FFD6, 1'b0);
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_and_check("mul_ovf_2p32", 34, 32'h0000_0000, 1'b1);
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'd1);
    wait_and_check("mul_min_x1", 34, 32'h8000_0000, 1'b0);
    start_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
    wait_and_check("mul_-3x-5", 34, 32'd15, 1'b0);
    start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2);
    wait_and_check("mul_ovf_pos", 34, 32'hFFFF_FFFE, 1'b1);

    // Divide
    start_op(1'b0, 1'b1, 32'hFFFF_FFD5, 32'd5);
    wait_and_check("div_-43/5", 35, 32'hFFFF_FFF8, 1'b0);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_and_check("div_min/-1", 35, 32'h8000_0000, 1'b1);
    start_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_and_check("div_7/-2", 35, 32'hFFFF_FFFD, 1'b0);
    start_op(1'b0, 1'b1, 32'd100, 32'd0);
    wait_and_check("div_by_zero", 35, 32'd0, 1'b1);

    // Result/exception held until the next start, which clears the exception
    repeat (5) @(negedge clock);
    check("hold_result", data_result, 32'd0);
    check("hold_exception", {31'b0, data_exception}, 32'd1);
    start_op(1'b1, 1'b0, 32'd2, 32'd3);
    @(negedge clock);
    check("start_clears_exception", {31'b0, data_exception}, 32'd0);
    check("start_busy", {31'b0, busy}, 32'd1);
    wait_and_check("mul_2x3", 33, 32'd6, 1'b0);

    // Restart a multiply with a divide in cycle 10
    start_op(1'b1, 1'b0, 32'd9, 32'd9);
    rdy_seen = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("restart_no_early_rdy", rdy_seen, 0);
    start_op(1'b0, 1'b1, 32'd20, 32'd3);
    wait_and_check("restart_div_20/3", 35, 32'd6, 1'b0);

    // Both starts at once: multiply performed
    start_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFA);
    wait_and_check("both_start_mul", 34, 32'hFFFF_FFD6, 1'b0);

    // Reset in cycle 15 of a divide
    start_op(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (14) @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("midrst_result", data_result, 32'd0);
    check("midrst_exception", {31'b0, data_exception}, 32'd0);
    check("midrst_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_state_idle", 32'(dut.state_q), 32'd0);
    rdy_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("midrst_no_rdy", rdy_seen, 0);

    // Start on the same edge as reset is ignored
    @(negedge clock);
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    ctrl_MULT     = 1'b1;
    reset         = 1'b0;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    reset     = 1'b1;
    rdy_seen  = 0;
    busy_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
      if (busy) busy_seen++;
    end
    check("rst_start_no_rdy", rdy_seen, 0);
    check("rst_start_no_busy", busy_seen, 0);
    check("rst_start_result", data_result, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
